// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// stall bus width, stall vector constants and FSM state encodings.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;
    localparam int CNT_W   = 6;
    localparam int PERF_W  = 32;

    typedef logic [STALL_W-1:0] stall_bus_t;

    // Freeze vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_IF   = 6'b000011;
    localparam stall_bus_t STALL_LU   = 6'b000111;
    localparam stall_bus_t STALL_MC   = 6'b001111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counters for the stall controller: cycles spent
// stalled and number of load-use bubbles inserted. Only built when
// PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_active,
    input  logic              lu_event,
    output logic [PERF_W-1:0] perf_stall_cyc,
    output logic [PERF_W-1:0] perf_lu_cnt
);

    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Count stalled cycles and load-use events, holding at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_lu_cnt    <= '0;
        end else begin
            if (stall_active && perf_stall_cyc != PERF_MAX)
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if (lu_event && perf_lu_cnt != PERF_MAX)
                perf_lu_cnt <= perf_lu_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: multi-cycle EX op sequencing, load-use hazard
// detection and fetch stall, prioritised into one freeze vector.
// Optional feature macro: PIPE_CTRL_PERF_EN adds perf_stall_cyc/perf_lu_cnt.
//
// state | meaning
// IDLE  | no multi-cycle op in flight
// BUSY  | multi-cycle op running in EX, cnt counts remaining stall cycles
//
// An op of length L stalls for L-1 cycles: the request cycle plus L-2 BUSY
// cycles. cnt is loaded with L-2; the FSM leaves BUSY on the edge where cnt
// reaches 0. L=2 loads cnt=0, so its single BUSY cycle is the exit cycle
// and does not stall.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_reg1_read,
    input  logic [4:0] id_reg1_addr,
    input  logic       id_reg2_read,
    input  logic [4:0] id_reg2_addr,
    input  logic       ex_is_load,
    input  logic       ex_wreg,
    input  logic [4:0] ex_wd,
    input  logic       ex_mc_req,
    input  logic [5:0] ex_mc_len,
    input  logic       if_stall_req,
    output logic [5:0] stall,
    output logic       ex_bubble,
    output logic       busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_lu_cnt
`endif
);

    mc_state_t        state;
    mc_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             mc_stall;
    logic             lu_hazard;
    logic             lu_taken;

    // Load-use hazard: ID needs the register a load in EX is about to write
    always_comb begin
        lu_hazard = ex_is_load && ex_wreg && (ex_wd != 5'd0) &&
                    ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                     (id_reg2_read && (id_reg2_addr == ex_wd)));
    end

    // Multi-cycle FSM state and counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Multi-cycle FSM next state and stall request
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mc_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ex_mc_req && (ex_mc_len >= 6'd2)) begin
                    state_nx = ST_BUSY;
                    cnt_nx   = ex_mc_len - 6'd2;
                    mc_stall = 1'b1;
                end
            end
            ST_BUSY: begin
                mc_stall = (cnt != '0);
                if (cnt <= 6'd1) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 6'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Prioritise stall sources; reset masks everything
    always_comb begin
        stall     = STALL_NONE;
        ex_bubble = 1'b0;
        lu_taken  = 1'b0;
        if (!rst) begin
            if (mc_stall) begin
                stall = STALL_MC;
            end else if (lu_hazard) begin
                stall     = STALL_LU;
                ex_bubble = 1'b1;
                lu_taken  = 1'b1;
            end else if (if_stall_req) begin
                stall = STALL_IF;
            end
        end
    end

    // busy follows the registered state, held low during reset
    always_comb begin
        busy = (state == ST_BUSY) && !rst;
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_active   (stall != STALL_NONE),
        .lu_event       (lu_taken),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_lu_cnt    (perf_lu_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Each cycle the expected outputs are
// queued when the inputs are driven and compared at the following negedge.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       id_reg1_read;
    logic [4:0] id_reg1_addr;
    logic       id_reg2_read;
    logic [4:0] id_reg2_addr;
    logic       ex_is_load;
    logic       ex_wreg;
    logic [4:0] ex_wd;
    logic       ex_mc_req;
    logic [5:0] ex_mc_len;
    logic       if_stall_req;
    logic [5:0] stall;
    logic       ex_bubble;
    logic       busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_lu_cnt;
`endif

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_IF   = 6'b000011;
    localparam logic [5:0] S_LU   = 6'b000111;
    localparam logic [5:0] S_MC   = 6'b001111;

    typedef struct {
        logic [5:0] stall;
        logic       bubble;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_reg1_read (id_reg1_read),
        .id_reg1_addr (id_reg1_addr),
        .id_reg2_read (id_reg2_read),
        .id_reg2_addr (id_reg2_addr),
        .ex_is_load   (ex_is_load),
        .ex_wreg      (ex_wreg),
        .ex_wd        (ex_wd),
        .ex_mc_req    (ex_mc_req),
        .ex_mc_len    (ex_mc_len),
        .if_stall_req (if_stall_req),
        .stall        (stall),
        .ex_bubble    (ex_bubble),
        .busy         (busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_lu_cnt    (perf_lu_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        id_reg1_read = 1'b0; id_reg1_addr = 5'd0;
        id_reg2_read = 1'b0; id_reg2_addr = 5'd0;
        ex_is_load   = 1'b0; ex_wreg      = 1'b0; ex_wd = 5'd0;
        ex_mc_req    = 1'b0; ex_mc_len    = 6'd0;
        if_stall_req = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] wd, input logic r1, input logic [4:0] a1,
                          input logic r2, input logic [4:0] a2);
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = wd;
        id_reg1_read = r1; id_reg1_addr = a1;
        id_reg2_read = r2; id_reg2_addr = a2;
    endtask

    // Inputs are already driven for this cycle: queue expectation, compare
    // at the negedge, then advance to just past the next rising edge.
    task automatic step(input string tag, input logic [5:0] s, input logic b, input logic bz);
        exp_t e;
        exp_t got;
        e.stall = s; e.bubble = b; e.busy = bz; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check({got.tag, ".stall"},  {26'd0, stall},     {26'd0, got.stall});
        check({got.tag, ".bubble"}, {31'd0, ex_bubble}, {31'd0, got.bubble});
        check({got.tag, ".busy"},   {31'd0, busy},      {31'd0, got.busy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        #1;
        // Reset masks outputs even with every request active
        ex_mc_req = 1'b1; ex_mc_len = 6'd5; if_stall_req = 1'b1;
        set_lu(5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
        step("rst0", S_NONE, 1'b0, 1'b0);
        step("rst1", S_NONE, 1'b0, 1'b0);
        clear_in();
        rst = 1'b0;
        step("idle", S_NONE, 1'b0, 1'b0);

        // len=4: request + 2 BUSY stalled cycles
        ex_mc_req = 1'b1; ex_mc_len = 6'd4;
        step("mc4_req", S_MC, 1'b0, 1'b0);
        clear_in();
        step("mc4_b1", S_MC, 1'b0, 1'b1);
        step("mc4_b2", S_MC, 1'b0, 1'b1);
        step("mc4_end", S_NONE, 1'b0, 1'b0);

        // Load-use cases
        set_lu(5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        step("lu_r2", S_LU, 1'b1, 1'b0);
        clear_in();
        step("lu_after", S_NONE, 1'b0, 1'b0);
        set_lu(5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
        step("lu_r0", S_NONE, 1'b0, 1'b0);
        set_lu(5'd17, 1'b1, 5'd17, 1'b0, 5'd3);
        step("lu_r1", S_LU, 1'b1, 1'b0);
        set_lu(5'd17, 1'b0, 5'd17, 1'b1, 5'd16);
        step("lu_noread", S_NONE, 1'b0, 1'b0);
        set_lu(5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
        ex_wreg = 1'b0;
        step("lu_nowreg", S_NONE, 1'b0, 1'b0);
        set_lu(5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
        ex_is_load = 1'b0;
        step("lu_noload", S_NONE, 1'b0, 1'b0);
        clear_in();

        // Fetch stall and its priority below load-use
        if_stall_req = 1'b1;
        step("fetch", S_IF, 1'b0, 1'b0);
        set_lu(5'd3, 1'b1, 5'd3, 1'b0, 5'd0);
        step("lu_fetch", S_LU, 1'b1, 1'b0);

        // All three at once: multi-cycle wins, no bubble
        ex_mc_req = 1'b1; ex_mc_len = 6'd3;
        step("all_req", S_MC, 1'b0, 1'b0);
        ex_mc_req = 1'b0;
        step("all_b1", S_MC, 1'b0, 1'b1);
        clear_in();
        step("all_end", S_NONE, 1'b0, 1'b0);

        // Short lengths
        ex_mc_req = 1'b1; ex_mc_len = 6'd1;
        step("len1", S_NONE, 1'b0, 1'b0);
        clear_in();
        step("len1_after", S_NONE, 1'b0, 1'b0);
        ex_mc_req = 1'b1; ex_mc_len = 6'd0;
        step("len0", S_NONE, 1'b0, 1'b0);
        ex_mc_len = 6'd2;
        step("len2_req", S_MC, 1'b0, 1'b0);
        clear_in();
        step("len2_exit", S_NONE, 1'b0, 1'b1);
        step("len2_end", S_NONE, 1'b0, 1'b0);

        // New request ignored while BUSY
        ex_mc_req = 1'b1; ex_mc_len = 6'd4;
        step("ign_req", S_MC, 1'b0, 1'b0);
        ex_mc_len = 6'd20;
        step("ign_b1", S_MC, 1'b0, 1'b1);
        clear_in();
        step("ign_b2", S_MC, 1'b0, 1'b1);
        step("ign_end", S_NONE, 1'b0, 1'b0);

        // Reset aborts a long op in its second BUSY cycle
        ex_mc_req = 1'b1; ex_mc_len = 6'd10;
        step("abort_req", S_MC, 1'b0, 1'b0);
        clear_in();
        step("abort_b1", S_MC, 1'b0, 1'b1);
        rst = 1'b1;
        step("abort_rst", S_NONE, 1'b0, 1'b0);
        rst = 1'b0;
        step("abort_after", S_NONE, 1'b0, 1'b0);
        step("abort_after2", S_NONE, 1'b0, 1'b0);

`ifdef PIPE_CTRL_PERF_EN
        rst = 1'b1;
        step("perf_rst", S_NONE, 1'b0, 1'b0);
        rst = 1'b0;
        check("perf_stall_clr", perf_stall_cyc, 32'd0);
        check("perf_lu_clr", perf_lu_cnt, 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_lu(5'(i + 1), 1'b1, 5'(i + 1), 1'b0, 5'd0);
            step("perf_lu", S_LU, 1'b1, 1'b0);
        end
        clear_in();
        if_stall_req = 1'b1;
        step("perf_if", S_IF, 1'b0, 1'b0);
        clear_in();
        step("perf_idle", S_NONE, 1'b0, 1'b0);
        check("perf_lu_cnt", perf_lu_cnt, 32'd5);
        check("perf_stall_cyc", perf_stall_cyc, 32'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: id_reg1_read  in  1  ID reads operand 1 from regfile.
REQ-004 SHALL have ports: id_reg1_addr  in  5  ID operand 1 register number.
REQ-005 SHALL have ports: id_reg2_read  in  1  ID reads operand 2 from regfile.
REQ-006 SHALL have ports: id_reg2_addr  in  5  ID operand 2 register number.
REQ-007 SHALL have ports: ex_is_load  in  1  instruction in EX is a load.
REQ-008 SHALL have ports: ex_wreg  in  1  EX instruction writes a register.
REQ-009 SHALL have ports: ex_wd  in  5  EX destination register.
REQ-010 SHALL have ports: ex_mc_req  in  1  EX starts a multi-cycle op (1-cycle pulse).
REQ-011 SHALL have ports: ex_mc_len  in  6  total EX cycles of that op.
REQ-012 SHALL have ports: if_stall_req  in  1  fetch not ready.
REQ-013 SHALL have ports: stall  out  6  freeze vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-014 SHALL have ports: ex_bubble  out  1  replace ID->EX transfer with NOP this cycle.
REQ-015 SHALL have ports: busy  out  1  multi-cycle FSM in BUSY.

Function
REQ-016 FSM states SHALL be IDLE and BUSY; 6-bit down-counter cnt.
REQ-017 IDLE->BUSY SHALL occur on ex_mc_req with ex_mc_len>=2, loading cnt=ex_mc_len-2; ex_mc_len 0 or 1 SHALL cause no stall, stay IDLE.
REQ-018 In BUSY cnt SHALL decrement each cycle; BUSY->IDLE when cnt==0 at the clock edge.
REQ-019 ex_mc_req SHALL be ignored while BUSY.
REQ-020 Multi-cycle stall (cycle of request with len>=2, and every BUSY cycle except last-count exit edge handled per REQ-018) SHALL drive stall=6'b001111, ex_bubble=0.
REQ-021 Load-use hazard = ex_is_load & ex_wreg & ex_wd!=0 & ((id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd)); combinational, same cycle.
REQ-022 Load-use SHALL drive stall=6'b000111, ex_bubble=1, for exactly that cycle (MEM forwarding resolves next cycle).
REQ-023 if_stall_req SHALL drive stall=6'b000011, ex_bubble=0.
REQ-024 Priority SHALL be multi-cycle > load-use > fetch; no request -> stall=0, ex_bubble=0.
REQ-025 Register $0 SHALL never cause a hazard.
REQ-026 busy SHALL be registered state (1 in BUSY).

Reset
REQ-027 rst SHALL force state=IDLE, cnt=0 at next edge, abandoning any op in progress.
REQ-028 While rst asserted, stall=0, ex_bubble=0, busy=0 irrespective of inputs.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN SHALL add outputs perf_stall_cyc (32) and perf_lu_cnt (32): cycles with stall!=0, and load-use events; saturate at 32'hFFFFFFFF; cleared by rst.
REQ-030 Without PIPE_CTRL_PERF_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared defines SHALL hold stall vector constants (STALL_NONE, STALL_IF, STALL_LU, STALL_MC), FSM state encodings, and StallBus width.
REQ-032 Sub-module pipe_ctrl_perf SHALL hold the counters, instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-033 ex_mc_req, len=4 -> stall=001111 for 3 cycles (request cycle + 2 BUSY), then 0; busy high 2 cycles.
REQ-034 ex_is_load, ex_wd=5, ex_wreg=1, id_reg2_read=1, addr=5 -> stall=000111, ex_bubble=1 one cycle; same with ex_wd=0 -> stall=0.
REQ-035 Load-use, if_stall_req, and ex_mc_req (len=3) same cycle -> stall=001111, ex_bubble=0.
REQ-036 rst asserted in 2nd BUSY cycle of len=10 op -> next cycle busy=0, stall=0.
REQ-037 ex_mc_len=1 -> no stall; with PIPE_CTRL_PERF_EN, 5 load-use events -> perf_lu_cnt=5.
